// File: rtl/ddr_packet_reader_if.sv
// Bus bundle for the DDR packet reader: the read request/response port
// toward the DDR bridge and the 32-bit beat stream toward the SFP TX path.
interface ddr_packet_reader_if;
    // DDR bridge read port
    logic         rd_rq;
    logic [24:0]  rd_adr;
    logic         rd_valid;
    logic [255:0] rd_data;

    // Outgoing beat stream
    logic [31:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_sop;
    logic         tx_eop;
    logic [1:0]   tx_empty;

    // Reader side
    modport master (
        output rd_rq,
        output rd_adr,
        input  rd_valid,
        input  rd_data,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        output tx_sop,
        output tx_eop,
        output tx_empty
    );

    // Bridge / sink side
    modport slave (
        input  rd_rq,
        input  rd_adr,
        output rd_valid,
        output rd_data,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        input  tx_sop,
        input  tx_eop,
        input  tx_empty
    );
endinterface

// File: rtl/ddr_packet_reader.sv
// Replays one stored packet from DDR per start pulse: reads a header word
// holding the byte length, then fetches 256-bit data words one at a time and
// streams them out as 32-bit beats, lane 0 first.
module ddr_packet_reader #(
    parameter logic [24:0] HDR_ADDR = 25'd1,
    parameter int unsigned MAX_LEN  = 1024,
    parameter int unsigned TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 setup_done,
    input  logic                 start,
    ddr_packet_reader_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdHdr,
        StWaitHdr,
        StRdData,
        StWaitData,
        StStream,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      len_lo_q, len_lo_d;
    logic [13:0]     beats_q, beats_d;
    logic [13:0]     beat_cnt_q, beat_cnt_d;
    logic [2:0]      lane_q, lane_d;
    logic [24:0]     word_adr_q, word_adr_d;
    logic [255:0]    line_q, line_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    logic [15:0]     hdr_len;
    logic            hdr_bad;
    logic            to_hit;
    logic            last_beat;

    assign hdr_len   = bus.rd_data[15:0];
    assign hdr_bad   = (hdr_len == 16'd0) || (32'(hdr_len) > MAX_LEN);
    // Last waiting cycle; rd_valid arriving in it still takes priority.
    assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign last_beat = (beat_cnt_q == beats_q - 14'd1);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_lo_q   <= '0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            lane_q     <= '0;
            word_adr_q <= '0;
            line_q     <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            lane_q     <= lane_d;
            word_adr_q <= word_adr_d;
            line_q     <= line_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic for the fetch/stream sequence
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        lane_d     = lane_q;
        word_adr_d = word_adr_q;
        line_d     = line_q;
        to_cnt_d   = to_cnt_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && setup_done) begin
                    beat_cnt_d = '0;
                    lane_d     = '0;
                    state_d    = StRdHdr;
                end
            end
            StRdHdr: begin
                to_cnt_d = '0;
                state_d  = StWaitHdr;
            end
            StWaitHdr: begin
                if (bus.rd_valid) begin
                    len_lo_d = hdr_len[1:0];
                    if (hdr_bad) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        beats_d    = 14'((32'(hdr_len) + 32'd3) >> 2);
                        word_adr_d = HDR_ADDR + 25'd1;
                        state_d    = StRdData;
                    end
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StRdData: begin
                to_cnt_d = '0;
                state_d  = StWaitData;
            end
            StWaitData: begin
                if (bus.rd_valid) begin
                    line_d  = bus.rd_data;
                    lane_d  = '0;
                    state_d = StStream;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StStream: begin
                if (bus.tx_ready) begin
                    beat_cnt_d = beat_cnt_q + 14'd1;
                    lane_d     = lane_q + 3'd1;
                    if (last_beat) begin
                        state_d = StDone;
                    end else if (lane_q == 3'd7) begin
                        word_adr_d = word_adr_q + 25'd1;
                        state_d    = StRdData;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from state and counters
    always_comb begin
        bus.rd_rq    = 1'b0;
        bus.rd_adr   = '0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_sop   = 1'b0;
        bus.tx_eop   = 1'b0;
        bus.tx_empty = '0;

        if (state_q == StRdHdr) begin
            bus.rd_rq  = 1'b1;
            bus.rd_adr = HDR_ADDR;
        end
        if (state_q == StRdData) begin
            bus.rd_rq  = 1'b1;
            bus.rd_adr = word_adr_q;
        end
        if (state_q == StStream) begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = line_q[{lane_q, 5'd0} +: 32];
            bus.tx_sop   = (beat_cnt_q == 14'd0);
            bus.tx_eop   = last_beat;
            // (4 - len%4) % 4 is the two's complement of the low length bits
            bus.tx_empty = last_beat ? (2'd0 - len_lo_q) : 2'd0;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign err  = err_q;

endmodule
